// File: rtl/x_dpram_be_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: read-during-write
// mode codes, controller states and the byte-lane count derivation.
package x_dpram_be_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef enum logic {
    DPRAM_INIT = 1'b0,
    DPRAM_RUN  = 1'b1
  } dpram_state_t;

  // Number of byte lanes in a word; DATA_W must be a multiple of BYTE_W.
  function automatic int lane_count(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/x_dpram_lane.sv
// One byte-lane column of the dual-port RAM: two write ports with
// write-enable masking and two registered reads of pre-write contents.
module x_dpram_lane #(
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_rd,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BYTE_W-1:0] a_din,
  output logic [BYTE_W-1:0] a_q,
  input  logic              b_rd,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BYTE_W-1:0] b_din,
  output logic [BYTE_W-1:0] b_q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [BYTE_W-1:0] mem [0:DEPTH-1];
  logic              a_wr;
  logic              b_wr;

  assign a_wr = a_en & a_we;
  assign b_wr = b_en & b_we;

  // Array write: B is applied first so an A write to the same word lands last.
  // NOTE: the storage array has no reset; resetting it would prevent RAM
  // inference, and clearing is done by the controller's clear sequence.
  always_ff @(posedge clk) begin
    if (b_wr) mem[b_addr] <= b_din;
    if (a_wr) mem[a_addr] <= a_din;
  end

  // Read registers capture the old contents on each accepted read and hold otherwise.
  // NOTE: non-blocking assignment means the read sees the value before this
  // edge's write; forwarding of new data is handled by the top level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_rd) a_q <= mem[a_addr];
      if (b_rd) b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/x_dpram_be.sv
// Single-clock true dual-port RAM with byte enables, selectable same-port
// read-during-write, cross-port forwarding, collision flag, optional output
// register and a post-reset clear sequence.
module x_dpram_be
  import x_dpram_be_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1,
  localparam int NB = lane_count(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  input  logic              a_en,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [NB-1:0]     b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              coll
);

  localparam logic OWN_FWD = (RDW_MODE == RDW_WRITE_FIRST);

  dpram_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              a_acc, b_acc;
  logic              same_addr;
  logic [NB-1:0]     a_wm, b_wm, a_fm, b_fm;
  logic [DATA_W-1:0] a_fd, b_fd;
  logic [NB-1:0]     a_fm_q, b_fm_q;
  logic [DATA_W-1:0] a_fd_q, b_fd_q;
  logic [DATA_W-1:0] a_old, b_old, a_rd, b_rd;
  logic              a_v1, b_v1;
  logic              la_en;
  logic [NB-1:0]     la_we;
  logic [ADDR_W-1:0] la_addr;
  logic [DATA_W-1:0] la_din;

  assign clearing  = (state == DPRAM_INIT);
  assign init_busy = clearing;
  assign a_acc     = a_en & ~clearing;
  assign b_acc     = b_en & ~clearing;
  assign same_addr = (a_addr == b_addr);

  // State register and clear counter; reset always restarts the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= (INIT_CLEAR != 0) ? DPRAM_INIT : DPRAM_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clearing) cnt <= cnt + 1'b1;
    end
  end

  // Next state: leave INIT after the last word has been cleared.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DPRAM_INIT: if (&cnt) state_nxt = DPRAM_RUN;
      DPRAM_RUN:  state_nxt = DPRAM_RUN;
    endcase
  end

  // Port A of every lane is borrowed by the clear sequence during INIT.
  assign la_en   = clearing | a_acc;
  assign la_we   = clearing ? '1 : a_we;
  assign la_addr = clearing ? cnt : a_addr;
  assign la_din  = clearing ? '0 : a_din;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    x_dpram_lane #(
      .BYTE_W (BYTE_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .a_rd   (a_acc),
      .a_en   (la_en),
      .a_we   (la_we[i]),
      .a_addr (la_addr),
      .a_din  (la_din[i*BYTE_W +: BYTE_W]),
      .a_q    (a_old[i*BYTE_W +: BYTE_W]),
      .b_rd   (b_acc),
      .b_en   (b_acc),
      .b_we   (b_we[i]),
      .b_addr (b_addr),
      .b_din  (b_din[i*BYTE_W +: BYTE_W]),
      .b_q    (b_old[i*BYTE_W +: BYTE_W])
    );
  end

  // Forwarding decision per lane: own writes follow RDW_MODE, lanes written only
  // by the other port at the same address always forward; overlapping lanes carry
  // port A's data.
  always_comb begin
    a_wm = a_acc ? a_we : '0;
    b_wm = b_acc ? b_we : '0;
    a_fm = (OWN_FWD ? a_wm : '0) | (same_addr ? (b_wm & ~a_wm) : '0);
    b_fm = (OWN_FWD ? b_wm : '0) | (same_addr ? (a_wm & ~b_wm) : '0);
    a_fd = b_din;
    b_fd = b_din;
    for (int i = 0; i < NB; i++) begin
      if (a_wm[i])              a_fd[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
      if (same_addr && a_wm[i]) b_fd[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
    end
  end

  // First read stage: valids, collision flag and forwarding overlay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_v1   <= 1'b0;
      b_v1   <= 1'b0;
      coll   <= 1'b0;
      a_fm_q <= '0;
      b_fm_q <= '0;
      a_fd_q <= '0;
      b_fd_q <= '0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      coll <= a_acc & b_acc & same_addr & (|(a_we & b_we));
      if (a_acc) begin
        a_fm_q <= a_fm;
        a_fd_q <= a_fd;
      end
      if (b_acc) begin
        b_fm_q <= b_fm;
        b_fd_q <= b_fd;
      end
    end
  end

  // Merge forwarded lanes over the old data from the array.
  always_comb begin
    a_rd = a_old;
    b_rd = b_old;
    for (int i = 0; i < NB; i++) begin
      if (a_fm_q[i]) a_rd[i*BYTE_W +: BYTE_W] = a_fd_q[i*BYTE_W +: BYTE_W];
      if (b_fm_q[i]) b_rd[i*BYTE_W +: BYTE_W] = b_fd_q[i*BYTE_W +: BYTE_W];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] a_dout_q, b_dout_q;
    logic              a_v2, b_v2;

    // Optional output register: one more cycle of latency, data held between reads.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_v2     <= 1'b0;
        b_v2     <= 1'b0;
        a_dout_q <= '0;
        b_dout_q <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_dout_q <= a_rd;
        if (b_v1) b_dout_q <= b_rd;
      end
    end

    assign a_dout  = a_dout_q;
    assign b_dout  = b_dout_q;
    assign a_valid = a_v2;
    assign b_valid = b_v2;
  end else begin : g_nreg
    assign a_dout  = a_rd;
    assign b_dout  = b_rd;
    assign a_valid = a_v1;
    assign b_valid = b_v1;
  end

endmodule

// File: tb/tb_x_dpram_be.sv
// Self-checking bench for x_dpram_be: directed scenarios plus random
// dual-port traffic against a word-array reference model.
module tb_x_dpram_be;

  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int NB         = DATA_W / BYTE_W;
  localparam int ADDR_W     = 12;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int RDW_MODE   = 0;
  localparam int OUT_REG    = 0;
  localparam int INIT_CLEAR = 1;
  localparam int LAT        = (OUT_REG != 0) ? 2 : 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_busy;
  logic              a_en, b_en;
  logic [NB-1:0]     a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_din, b_din, a_dout, b_dout;
  logic              a_valid, b_valid, coll;

  x_dpram_be #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
    .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG), .INIT_CLEAR(INIT_CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_valid(b_valid),
    .coll(coll)
  );

  always #5 clk = ~clk;

  // Vector layout: {busy, a_valid, a_dout, b_valid, b_dout, coll}
  localparam int VW = 3 + 2 * DATA_W + 1;
  logic [VW-1:0] got, exp_v;
  logic [VW-1:0] trace [$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DATA_W-1:0] mem_m [DEPTH];
  int                m_cnt;
  logic              e_av, e_bv, e_coll, s1_av, s1_bv;
  logic [DATA_W-1:0] e_ad, e_bd, s1_ad, s1_bd;

  function automatic logic m_busy();
    return (INIT_CLEAR != 0) && (m_cnt < DEPTH);
  endfunction

  function automatic logic [VW-1:0] sample();
    return {init_busy, a_valid, a_dout, b_valid, b_dout, coll};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    m_cnt = 0;
    e_av = 0; e_bv = 0; e_coll = 0; s1_av = 0; s1_bv = 0;
    e_ad = '0; e_bd = '0; s1_ad = '0; s1_bd = '0;
  endtask

  // One clock: apply inputs, advance the model, sample after the edge.
  task automatic drive(input logic ae, input logic [NB-1:0] awe, input logic [ADDR_W-1:0] aad,
                       input logic [DATA_W-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                       input logic [ADDR_W-1:0] bad, input logic [DATA_W-1:0] bd);
    logic acc_a, acc_b, same;
    logic [NB-1:0] wa, wb;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, ra, rb;
    a_en = ae; a_we = awe; a_addr = aad; a_din = ad;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bd;
    acc_a = ae && !m_busy();
    acc_b = be && !m_busy();
    wa = acc_a ? awe : '0;
    wb = acc_b ? bwe : '0;
    same  = (aad == bad);
    old_a = mem_m[aad];
    old_b = mem_m[bad];
    // Port A has priority, so its lanes are written after B's.
    for (int i = 0; i < NB; i++) if (wb[i]) mem_m[bad][i*BYTE_W +: BYTE_W] = bd[i*BYTE_W +: BYTE_W];
    for (int i = 0; i < NB; i++) if (wa[i]) mem_m[aad][i*BYTE_W +: BYTE_W] = ad[i*BYTE_W +: BYTE_W];
    new_a = mem_m[aad];
    new_b = mem_m[bad];
    for (int i = 0; i < NB; i++) begin
      ra[i*BYTE_W +: BYTE_W] = ((wa[i] && RDW_MODE == 0) || (!wa[i] && same && wb[i]))
                               ? new_a[i*BYTE_W +: BYTE_W] : old_a[i*BYTE_W +: BYTE_W];
      rb[i*BYTE_W +: BYTE_W] = ((wb[i] && RDW_MODE == 0) || (!wb[i] && same && wa[i]))
                               ? new_b[i*BYTE_W +: BYTE_W] : old_b[i*BYTE_W +: BYTE_W];
    end
    @(posedge clk);
    e_coll = acc_a && acc_b && same && ((wa & wb) != '0);
    if (OUT_REG == 0) begin
      e_av = acc_a; if (acc_a) e_ad = ra;
      e_bv = acc_b; if (acc_b) e_bd = rb;
    end else begin
      e_av = s1_av; if (s1_av) e_ad = s1_ad;
      e_bv = s1_bv; if (s1_bv) e_bd = s1_bd;
      s1_av = acc_a; if (acc_a) s1_ad = ra;
      s1_bv = acc_b; if (acc_b) s1_bd = rb;
    end
    m_cnt++;
    @(negedge clk);
    got   = sample();
    exp_v = {m_busy(), e_av, e_ad, e_bv, e_bd, e_coll};
    trace.push_back(got);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_en = 0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 0; b_we = '0; b_addr = '0; b_din = '0;
    model_reset();
    #12;
    got = sample();
    exp_v = {1'b1, {(VW-1){1'b0}}};
    n_checks++;
    if (got !== exp_v) $display("FAIL reset_state got=%h want=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Clear must hold init_busy for exactly DEPTH cycles; junk writes to 0x5 are ignored.
  task automatic test_init_clear(input string name);
    int n = 0;
    while (init_busy === 1'b1 && n < DEPTH + 16) begin
      drive(1'b1, '1, 12'h005, $urandom, 1'b1, '1, 12'h005, $urandom);
      n++;
      n_checks++;
      if (got !== exp_v) begin
        if (n_checks - n_pass < 10) $display("FAIL %s cycle %0d got=%h want=%h", name, n, got, exp_v);
      end else n_pass++;
    end
    n_checks++;
    if (n !== DEPTH) $display("FAIL %s_busy_cycles got=%0d want=%0d", name, n, DEPTH);
    else n_pass++;
  endtask

  task automatic test_read_after_clear();
    trace.delete();
    drive(1'b1, '0, 12'h000, '0, 1'b1, '0, 12'hFFF, '0);
    drive(1'b1, '0, 12'h005, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < LAT; i++) idle();
    for (int i = 0; i < trace.size(); i++) begin
      n_checks++;
      if (trace[i] !== {1'b0, i == LAT-1 || i == LAT, 32'h0, i == LAT-1, 32'h0, 1'b0})
        $display("FAIL read_after_clear step %0d got=%h", i, trace[i]);
      else n_pass++;
    end
  endtask

  task automatic test_byte_enable();
    logic [VW-1:0] r;
    trace.delete();
    drive(1'b1, 4'b1111, 12'h010, 32'h11223344, 1'b0, '0, '0, '0);
    idle();
    drive(1'b1, 4'b0101, 12'h010, 32'hAABBCCDD, 1'b0, '0, '0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'b0000, 12'h010, '0);
    for (int i = 0; i < LAT; i++) begin
      n_checks++;
      if (got !== exp_v) $display("FAIL byte_enable_model got=%h want=%h", got, exp_v);
      else n_pass++;
      idle();
    end
    r = trace[3 + LAT - 1];
    n_checks++;
    if (r[33] !== 1'b1 || r[32:1] !== 32'h11BB33DD)
      $display("FAIL byte_enable_read b_valid=%b b_dout=%h want 1/11bb33dd", r[33], r[32:1]);
    else n_pass++;
    r = trace[3 + LAT - 2];
    n_checks++;
    if (r[33] !== 1'b0) $display("FAIL byte_enable_latency early b_valid=%b want 0", r[33]);
    else n_pass++;
  endtask

  task automatic test_forward();
    logic [VW-1:0] r;
    logic [DATA_W-1:0] want_a;
    trace.delete();
    want_a = (RDW_MODE == 0) ? 32'hCAFEBABE : 32'h0;
    drive(1'b1, 4'b1111, 12'h020, 32'hCAFEBABE, 1'b1, 4'b0000, 12'h020, '0);
    for (int i = 0; i < LAT; i++) idle();
    r = trace[LAT - 1];
    n_checks++;
    if (r[33] !== 1'b1 || r[32:1] !== 32'hCAFEBABE)
      $display("FAIL cross_forward b_valid=%b b_dout=%h want 1/cafebabe", r[33], r[32:1]);
    else n_pass++;
    n_checks++;
    if (r[66] !== 1'b1 || r[65:34] !== want_a)
      $display("FAIL same_port_rdw a_valid=%b a_dout=%h want 1/%h", r[66], r[65:34], want_a);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [VW-1:0] r;
    trace.delete();
    drive(1'b1, 4'b0011, 12'h030, 32'hAAAAAAAA, 1'b1, 4'b0110, 12'h030, 32'hBBBBBBBB);
    drive(1'b1, 4'b0000, 12'h030, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < LAT; i++) idle();
    for (int i = 0; i < trace.size(); i++) begin
      n_checks++;
      if (trace[i][0] !== (i == 0)) $display("FAIL coll_pulse step %0d coll=%b want %b", i, trace[i][0], i == 0);
      else n_pass++;
    end
    r = trace[1 + LAT - 1];
    n_checks++;
    if (r[66] !== 1'b1 || r[65:34] !== 32'h00BBAAAA)
      $display("FAIL coll_merge a_valid=%b a_dout=%h want 1/00bbaaaa", r[66], r[65:34]);
    else n_pass++;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int k = $urandom_range(0, 4);
    return (k == 4) ? 12'hFFF : 12'(k);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
            pick_addr(), $urandom,
            $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
            pick_addr(), $urandom);
      n_checks++;
      if (got !== exp_v) begin
        if (n_checks - n_pass < 10) $display("FAIL random cycle %0d got=%h want=%h", c, got, exp_v);
      end else n_pass++;
    end
    for (int i = 0; i < LAT; i++) begin
      idle();
      n_checks++;
      if (got !== exp_v) $display("FAIL random_drain got=%h want=%h", got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_init();
    for (int i = 0; i < 100; i++) idle();
    reset = 1'b0;
    model_reset();
    #2;
    got = sample();
    n_checks++;
    if (got !== {1'b1, {(VW-1){1'b0}}}) $display("FAIL reset_mid_init got=%h", got);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    test_init_clear("clear_after_mid_init");
  endtask

  task automatic test_reset_pending_read();
    a_en = 1'b1; a_we = '0; a_addr = 12'h010;
    b_en = 1'b1; b_we = '0; b_addr = 12'hFFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_en = 1'b0; b_en = 1'b0;
    model_reset();
    #1;
    got = sample();
    n_checks++;
    if (got !== {1'b1, {(VW-1){1'b0}}}) $display("FAIL reset_pending_read got=%h", got);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    test_init_clear("clear_after_pending");
    drive(1'b1, '0, 12'h010, '0, 1'b1, '0, 12'h030, '0);
    for (int i = 0; i < LAT; i++) idle();
    n_checks++;
    if (got !== exp_v || got[65:34] !== 32'h0) $display("FAIL reread_after_clear got=%h want=%h", got, exp_v);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_clear("init_clear");
    test_read_after_clear();
    test_byte_enable();
    test_forward();
    test_collision();
    test_random();
    test_reset_mid_init();
    test_reset_pending_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
